// File: rtl/microc_defs.sv
// Shared constants for the microc control path: opcode encodings, ALU class
// bit and the control FSM state encoding.
package microc_defs;

    localparam logic [5:0] OP_LI   = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000100;
    localparam logic [5:0] OP_JZ   = 6'b000101;
    localparam logic [5:0] OP_JNZ  = 6'b000110;
    localparam logic [5:0] OP_HALT = 6'b000111;

    localparam int ALU_BIT = 5;

    localparam logic [2:0] ALU_NONE = 3'b000;

    // Bit 0 marks HALT so the halted output can be taken straight off the flop.
    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    function automatic logic is_li(input logic [5:0] opcode);
        return opcode[5:2] == OP_LI[5:2];
    endfunction

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode decoder producing raw (ungated) datapath controls.
module uc_decode
    import microc_defs::*;
(
    input  logic [5:0] Opcode,
    input  logic       z,
    output logic       s_inc,
    output logic       s_inm,
    output logic       we3,
    output logic       wez,
    output logic [2:0] Op,
    output logic       is_halt
);

    always_comb begin
        s_inc   = 1'b1;
        s_inm   = 1'b0;
        we3     = 1'b0;
        wez     = 1'b0;
        Op      = ALU_NONE;
        is_halt = 1'b0;
        if (Opcode[ALU_BIT]) begin
            Op  = Opcode[4:2];
            we3 = 1'b1;
            wez = 1'b1;
        end else if (is_li(Opcode)) begin
            s_inm = 1'b1;
            we3   = 1'b1;
        end else begin
            // Anything not listed here falls through as a NOP.
            case (Opcode)
                OP_J:    s_inc = 1'b0;
                OP_JZ:   s_inc = ~z;
                OP_JNZ:  s_inc = z;
                OP_HALT: is_halt = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ucontrol.sv
// Control unit for microc: decode wrapped in a run/halt/single-step debug FSM
// that gates PC advance and register writes, plus a retired-instruction counter.
module ucontrol
    import microc_defs::*;
#(
    parameter bit START_RUN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             z,
    input  logic             stop,
    input  logic             go,
    input  logic             step,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       Op,
    output logic             pc_en,
    output logic             halted,
    output logic [CNT_W-1:0] icount
);

    localparam state_t RESET_STATE = START_RUN ? ST_RUN : ST_HALT;

    state_t     state;
    state_t     state_next;
    logic       dec_s_inc;
    logic       dec_s_inm;
    logic       dec_we3;
    logic       dec_wez;
    logic [2:0] dec_op;
    logic       dec_is_halt;

    uc_decode u_decode (
        .Opcode  (Opcode),
        .z       (z),
        .s_inc   (dec_s_inc),
        .s_inm   (dec_s_inm),
        .we3     (dec_we3),
        .wez     (dec_wez),
        .Op      (dec_op),
        .is_halt (dec_is_halt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Executing states pass the decoder through; HALT forces safe, write-free controls.
    always_comb begin
        state_next = state;
        pc_en      = 1'b0;
        s_inc      = 1'b1;
        s_inm      = 1'b0;
        we3        = 1'b0;
        wez        = 1'b0;
        Op         = ALU_NONE;
        case (state)
            ST_RUN: begin
                pc_en = 1'b1;
                s_inc = dec_s_inc;
                s_inm = dec_s_inm;
                we3   = dec_we3;
                wez   = dec_wez;
                Op    = dec_op;
                if (dec_is_halt || stop) begin
                    state_next = ST_HALT;
                end
            end
            ST_STEP: begin
                pc_en      = 1'b1;
                s_inc      = dec_s_inc;
                s_inm      = dec_s_inm;
                we3        = dec_we3;
                wez        = dec_wez;
                Op         = dec_op;
                state_next = ST_HALT;
            end
            ST_HALT: begin
                if (go) begin
                    state_next = ST_RUN;
                end else if (step) begin
                    state_next = ST_STEP;
                end
            end
            default: state_next = ST_HALT;
        endcase
    end

    assign halted = state[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            icount <= '0;
        end else if (pc_en) begin
            icount <= icount + CNT_W'(1);
        end
    end

endmodule
